// File: rtl/adxl357_frame_unpacker.sv
// adxl357_frame_unpacker: captures ADXL357 11-byte bursts, unpacks temp/XYZ, box-averages 2^n frames.
// Ports: i_clk/i_rst clock and sync reset; i_enable block enable; i_finish controller done level;
// i_frame 11 burst bytes (byte k at [8k+7:8k]); i_avg_log2 averaging exponent; i_ready downstream ready;
// o_valid/o_temp/o_x/o_y/o_z result stream; o_frame_cnt accepted frames; o_drop_cnt dropped results;
// o_stale no frame seen for TIMEOUT_CYC enabled cycles.
module adxl357_frame_unpacker #(
    parameter int MAX_AVG_LOG2 = 7,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_finish,
    input  logic [87:0] i_frame,
    input  logic [2:0]  i_avg_log2,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [11:0] o_temp,
    output logic [31:0] o_x,
    output logic [31:0] o_y,
    output logic [31:0] o_z,
    output logic [31:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt,
    output logic        o_stale
);
    localparam int AW = 20 + MAX_AVG_LOG2;
    localparam int CW = MAX_AVG_LOG2 + 1;
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] NMAX = 3'(MAX_AVG_LOG2);
    typedef enum logic [1:0] {IDLE, UNPACK, EMIT} state_t;
    state_t state_q, state_d;
    logic finish_q, pending_q, pending_d, valid_q, valid_d;
    logic [87:0] cap_q;
    logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] n_cur_q, n_cur_d, n_in, n_use;
    logic [11:0] temp_q, temp_d, otemp_q, otemp_d, temp_now;
    logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_q, drop_d;
    logic [SW-1:0] stale_q, stale_d;
    logic signed [19:0] ax, ay, az;
    logic frame_edge, pend_any, last, stale_hit, unused_bits;
    assign frame_edge = i_finish & ~finish_q & i_enable;
    // An edge in the current cycle counts as pending so the FSM reaches UNPACK one cycle after capture.
    assign pend_any = pending_q | frame_edge;
    assign temp_now = {cap_q[3:0], cap_q[15:8]};
    assign ax = {cap_q[23:16], cap_q[31:24], cap_q[39:36]};
    assign ay = {cap_q[47:40], cap_q[55:48], cap_q[63:60]};
    assign az = {cap_q[71:64], cap_q[79:72], cap_q[87:84]};
    assign unused_bits = ^{cap_q[7:4], cap_q[35:32], cap_q[59:56], cap_q[83:80]};
    assign n_in = (i_avg_log2 > NMAX) ? NMAX : i_avg_log2;
    // The exponent is latched at the first frame of a block so mid-block changes wait for the next block.
    assign n_use = (cnt_q == '0) ? n_in : n_cur_q;
    assign last = (cnt_q + CW'(1)) == (CW'(1) << n_use);
    assign stale_hit = stale_q == SW'(TIMEOUT_CYC);
    assign o_valid = valid_q;
    assign o_temp = otemp_q;
    assign o_x = x_q;
    assign o_y = y_q;
    assign o_z = z_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_drop_cnt = drop_q;
    assign o_stale = stale_hit;
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = IDLE;
        if (i_enable)
            unique case (state_q)
                IDLE:    state_d = pend_any ? UNPACK : IDLE;
                UNPACK:  state_d = last ? EMIT : IDLE;
                EMIT:    state_d = pend_any ? UNPACK : IDLE;
                default: state_d = IDLE;
            endcase
    end
    always_comb begin
        pending_d = frame_edge | (pending_q & (state_q != UNPACK));
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        acc_z_d = acc_z_q;
        cnt_d = cnt_q;
        n_cur_d = n_cur_q;
        temp_d = temp_q;
        valid_d = valid_q & ~i_ready;
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        otemp_d = otemp_q;
        drop_d = drop_q;
        frame_cnt_d = frame_cnt_q + {31'd0, frame_edge};
        stale_d = frame_edge ? '0 : (stale_hit ? stale_q : stale_q + SW'(1));
        if (state_q == UNPACK) begin
            acc_x_d = acc_x_q + AW'(ax);
            acc_y_d = acc_y_q + AW'(ay);
            acc_z_d = acc_z_q + AW'(az);
            cnt_d = cnt_q + CW'(1);
            n_cur_d = n_use;
            temp_d = temp_now;
        end
        if (i_enable && state_q == EMIT) begin
            acc_x_d = '0;
            acc_y_d = '0;
            acc_z_d = '0;
            cnt_d = '0;
            if (!valid_q || i_ready) begin
                x_d = 32'(acc_x_q) >>> n_cur_q;
                y_d = 32'(acc_y_q) >>> n_cur_q;
                z_d = 32'(acc_z_q) >>> n_cur_q;
                otemp_d = temp_q;
                valid_d = 1'b1;
            end else begin
                drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            end
        end
        if (!i_enable) begin
            acc_x_d = '0;
            acc_y_d = '0;
            acc_z_d = '0;
            cnt_d = '0;
            pending_d = 1'b0;
            stale_d = '0;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            finish_q <= 1'b0;
            cap_q <= '0;
            pending_q <= 1'b0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            acc_z_q <= '0;
            cnt_q <= '0;
            n_cur_q <= '0;
            temp_q <= '0;
            valid_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            otemp_q <= '0;
            drop_q <= '0;
            frame_cnt_q <= '0;
            stale_q <= '0;
        end else begin
            finish_q <= i_finish;
            if (frame_edge) cap_q <= i_frame;
            pending_q <= pending_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            acc_z_q <= acc_z_d;
            cnt_q <= cnt_d;
            n_cur_q <= n_cur_d;
            temp_q <= temp_d;
            valid_q <= valid_d;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            otemp_q <= otemp_d;
            drop_q <= drop_d;
            frame_cnt_q <= frame_cnt_d;
            stale_q <= stale_d;
        end
    end
endmodule
